imem_axil_rd_slave: RTL and testbench

AXI-lite read-channel responder for instruction memory. It accepts one AR request at a time from the fetch unit and issues a single access to a synchronous SRAM port. It then returns the 64-bit aligned doubleword on the R channel; the fetch side selects the 32-bit half itself using addr[2]. Out-of-range or misaligned requests get an error response with no SRAM access.

---
 rtl/imem_axil_rd_slave_pkg.sv | 19 +
 rtl/imem_axil_rd_slave_reg.sv | 20 ++
 rtl/imem_axil_rd_slave.sv | 114 +++++++++++
 tb/tb_imem_axil_rd_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_axil_rd_slave_pkg.sv
// Shared bus widths, response codes and FSM encoding for the instruction-memory
// AXI-lite read responder.
package imem_axil_rd_slave_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned MemDataBus = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMem  = 3'd1,
    StData = 3'd2,
    StWait = 3'd3,
    StResp = 3'd4
  } state_e;

endpackage

// File: rtl/imem_axil_rd_slave_reg.sv
// Generic register primitive with synchronous, active-high reset to a fixed value.
module imem_axil_rd_slave_reg #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= ResetVal;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read responder for instruction memory: one outstanding AR, one SRAM
// access, full 64-bit doubleword returned on R; bad addresses get SLVERR.
module imem_axil_rd_slave
  import imem_axil_rd_slave_pkg::*;
#(
  parameter int unsigned        ADDR_W     = MemAddrBus,
  parameter int unsigned        DATA_W     = MemDataBus,
  parameter logic [ADDR_W-1:0]  BASE       = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  SIZE_BYTES = 32'h0010_0000,
  parameter int unsigned        LAT        = 0,
  parameter int unsigned        CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              ARREADY,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              RREADY,
  output logic              mem_en,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e             state_q, state_d;
  logic [2:0]         state_raw;
  logic               arready_d, rvalid_d;
  logic [DATA_W-1:0]  rdata_d;
  logic [1:0]         rresp_d;
  logic [ADDR_W-4:0]  mem_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  offset;
  logic               err;

  assign state_q = state_e'(state_raw);

  imem_axil_rd_slave_reg #(.Width(3), .ResetVal(StIdle)) u_state_reg (
    .clk(clk), .rst(rst), .d(state_d), .q(state_raw)
  );
  imem_axil_rd_slave_reg #(.Width(1)) u_arready_reg (
    .clk(clk), .rst(rst), .d(arready_d), .q(ARREADY)
  );
  imem_axil_rd_slave_reg #(.Width(1)) u_rvalid_reg (
    .clk(clk), .rst(rst), .d(rvalid_d), .q(RVALID)
  );
  imem_axil_rd_slave_reg #(.Width(DATA_W)) u_rdata_reg (
    .clk(clk), .rst(rst), .d(rdata_d), .q(RDATA)
  );
  imem_axil_rd_slave_reg #(.Width(2)) u_rresp_reg (
    .clk(clk), .rst(rst), .d(rresp_d), .q(RRESP)
  );
  imem_axil_rd_slave_reg #(.Width(ADDR_W-3)) u_mem_addr_reg (
    .clk(clk), .rst(rst), .d(mem_addr_d), .q(mem_addr)
  );
  imem_axil_rd_slave_reg #(.Width(CNT_W)) u_cnt_reg (
    .clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q)
  );

  // Offset wraps for addresses below BASE; the explicit compare catches that case.
  assign offset = ARADDR - BASE;
  assign err    = (ARADDR < BASE) | (offset >= SIZE_BYTES) | (ARADDR[1:0] != 2'b00);

  assign mem_en = (state_q == StMem);

  always_comb begin
    state_d    = state_q;
    rdata_d    = RDATA;
    rresp_d    = RRESP;
    mem_addr_d = mem_addr;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ARVALID && ARREADY) begin
          if (err) begin
            state_d = StResp;
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end else begin
            state_d    = StMem;
            mem_addr_d = offset[ADDR_W-1:3];
          end
        end
      end
      StMem: state_d = StData;
      StData: begin
        rdata_d = mem_rdata;
        rresp_d = RESP_OKAY;
        if (LAT == 0) begin
          state_d = StResp;
        end else begin
          cnt_d   = CNT_W'(LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered handshake outputs track the state being entered.
    arready_d = (state_d == StIdle);
    rvalid_d  = (state_d == StResp);
  end

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Scoreboard bench: two responders (LAT=0 and LAT=3) driven by directed and random
// AR traffic, checked cycle by cycle against an address-rule reference model.
module tb_imem_axil_rd_slave;

  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SIZE = 64'h0010_0000;

  typedef struct {
    logic [1:0]  resp;
    logic [63:0] data;
    int          due;
  } r_exp_t;

  typedef struct {
    logic [28:0] idx;
    int          due;
  } m_exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lat, input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL [LAT=%0d] %s at cycle %0d: got %h, expected %h", lat, nm, cyc, got, want);
    end
  endtask

  task automatic fail_now(input int lat, input string nm);
    checks++;
    errors++;
    $display("FAIL [LAT=%0d] %s at cycle %0d: got timeout, expected completion", lat, nm, cyc);
  endtask

  function automatic logic [63:0] sram_word(input logic [28:0] idx);
    if (idx == 29'd0) return 64'h00000513_00100093;
    return {3'b101, idx, 32'(idx) * 32'h9E37_79B9};
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
    longint unsigned la = 64'(a);
    return (la < BASE) || (la >= BASE + SIZE) || ((la % 4) != 0);
  endfunction

  function automatic logic [28:0] dw_index(input logic [31:0] a);
    return 29'((64'(a) - BASE) / 8);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 0 : 3;

    logic        rst = 1'b1;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic        arready, rvalid, mem_en;
    logic        rready = 1'b0;
    logic [63:0] rdata;
    logic [63:0] mem_rdata = '0;
    logic [1:0]  rresp;
    logic [28:0] mem_addr;
    int          rmode = 0;

    r_exp_t rq[$];
    m_exp_t mq[$];
    bit     busy = 1'b0;
    bit     exp_ardy = 1'b0;
    bit     prev_rst = 1'b1;

    imem_axil_rd_slave #(.LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .ARVALID(arvalid), .ARADDR(araddr), .ARREADY(arready),
      .RVALID(rvalid), .RDATA(rdata), .RRESP(rresp), .RREADY(rready),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Synchronous SRAM: data one cycle after the strobe, held otherwise.
    always @(posedge clk) if (mem_en) mem_rdata <= sram_word(mem_addr);

    always @(posedge clk) begin
      #2;
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b0;
      endcase
    end

    // Monitor: compare this cycle's outputs, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
      bit exp_rv, exp_me;
      r_exp_t r;
      chk(L, "arready", 64'(arready), 64'(exp_ardy));
      exp_rv = (rq.size() > 0) && (rq[0].due <= cyc);
      chk(L, "rvalid", 64'(rvalid), 64'(exp_rv));
      if (exp_rv && rvalid) begin
        chk(L, "rresp", 64'(rresp), 64'(rq[0].resp));
        chk(L, "rdata", rdata, rq[0].data);
      end
      exp_me = (mq.size() > 0) && (mq[0].due == cyc);
      chk(L, "mem_en", 64'(mem_en), 64'(exp_me));
      if (exp_me) begin
        if (mem_en) chk(L, "mem_addr", 64'(mem_addr), 64'(mq[0].idx));
        void'(mq.pop_front());
      end
      if (prev_rst) begin
        chk(L, "rdata_reset", rdata, 64'd0);
        chk(L, "rresp_reset", 64'(rresp), 64'd0);
      end
      if (rst) begin
        rq.delete();
        mq.delete();
        busy     = 1'b0;
        exp_ardy = 1'b0;
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        if (exp_rv && rready) begin
          void'(rq.pop_front());
          busy = 1'b0;
        end
        if (arvalid && arready) begin
          if (addr_err(araddr)) begin
            r.resp = 2'b10;
            r.data = '0;
            r.due  = cyc + 1;
          end else begin
            r.resp = 2'b00;
            r.data = sram_word(dw_index(araddr));
            r.due  = cyc + 3 + L;
            mq.push_back('{idx: dw_index(araddr), due: cyc + 1});
          end
          rq.push_back(r);
          busy = 1'b1;
        end
        exp_ardy = !busy;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic req(input logic [31:0] a, output int t);
      bit hs;
      arvalid = 1'b1;
      araddr  = a;
      t       = -1;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        hs = arready;
        if (hs) t = cyc;
        tick();
        if (hs) break;
      end
      if (t < 0) fail_now(L, "ar_handshake");
      arvalid = 1'b0;
      araddr  = $urandom;
    endtask

    task automatic wait_idle();
      int n = 0;
      while (busy) begin
        tick();
        if (++n > 200) begin
          fail_now(L, "r_beat");
          break;
        end
      end
    endtask

    task automatic wait_rvalid();
      int n = 0;
      while (!rvalid) begin
        tick();
        if (++n > 50) begin
          fail_now(L, "rvalid_rise");
          break;
        end
      end
    endtask

    initial begin
      int t, t0, t1, t2;
      logic [31:0] a;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      // Aligned and upper-half reads of doubleword 0, then the three error kinds.
      req(32'h8000_0000, t); wait_idle();
      req(32'h8000_0004, t); wait_idle();
      req(32'h7fff_fffc, t); wait_idle();
      req(32'h8000_0002, t); wait_idle();
      req(32'(BASE + SIZE), t); wait_idle();
      // Backpressure: hold RREADY low for 5 cycles after RVALID rises.
      rmode = 2;
      req(32'h8000_0018, t);
      wait_rvalid();
      repeat (5) tick();
      rmode = 0;
      wait_idle();
      // Back-to-back with ARVALID held high.
      req(32'h8000_0000, t0);
      req(32'h8000_0008, t1);
      req(32'h8000_0010, t2);
      chk(L, "b2b_spacing_1", 64'(t1 - t0), 64'(4 + L));
      chk(L, "b2b_spacing_2", 64'(t2 - t1), 64'(4 + L));
      wait_idle();
      // Random traffic with random RREADY.
      rmode = 1;
      repeat (60) begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = 32'(BASE) + 32'($urandom_range(0, 255)) * 4;
          3:       a = 32'(BASE + SIZE) - 32'($urandom_range(1, 4)) * 4;
          4:       a = ($urandom_range(0, 1) == 1) ?
                       32'(BASE) - 32'($urandom_range(1, 64)) * 4 : $urandom;
          default: a = 32'(BASE) + 32'($urandom_range(0, 1023)) * 4 +
                       32'($urandom_range(1, 3));
        endcase
        req(a, t);
        if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();
      // Reset while the read is in flight; no beat may follow.
      rmode = 0;
      req(32'h8000_0020, t);
      repeat ((L > 0) ? 2 : 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      req(32'h8000_0008, t);
      wait_idle();
      repeat (3) tick();
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 60000; n++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got unfinished stimulus, expected completion");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
